// File: rtl/seq_pkg.sv
// Shared definitions for the serial stimulus path feeding the 101 detector.
//   seq_state_t : serializer FSM states
//   cnt_w_of()  : bit-counter width for a given word length
package seq_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } seq_state_t;

  // Word length of the default serializer build.
  localparam int DEF_WIDTH = 8;

  // The counter counts down from WIDTH-1 to 0, so $clog2(WIDTH) bits are enough.
  // The floor of 1 keeps the vector legal for degenerate widths.
  function automatic int cnt_w_of(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-in / serial-out stage driving the serial input w of the 101 detector.
// A word is taken through a valid/ready handshake and shifted out one bit per
// clock. Words can stream back-to-back: a new word may be accepted in the cycle
// the previous word's last bit is on w.
//
// Ports
//   Clk        in   1      clock, rising edge
//   Reset      in   1      synchronous active-low reset
//   Din        in   WIDTH  parallel word, sampled only on an accepted handshake
//   Load_valid in   1      upstream offers a word
//   Load_ready out  1      word can be accepted this cycle (combinational)
//   w          out  1      serial bit (registered)
//   Busy       out  1      word in flight (registered)
//   Done       out  1      high while w carries a word's last bit (registered)
//
// state | meaning
// IDLE  | no word in flight, w = IDLE_BIT, ready
// SHIFT | word on w; ready only in its last-bit cycle (r_cnt == 0)
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             Load_valid,
  output logic             Load_ready,
  output logic             w,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = cnt_w_of(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  seq_state_t       r_state, w_state_n;
  logic [WIDTH-1:0] r_shift, w_shift_n, w_shifted;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic             r_w, w_w_n;
  logic             r_busy, w_busy_n;
  logic             r_done, w_done_n;
  logic             w_ready, w_accept;

  // Bit that goes out first from a given register image.
  function automatic logic head_of(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  assign w_ready  = (r_state == IDLE) || (r_cnt == '0);
  assign w_accept = Load_valid & w_ready;

  // w is registered, so the bit presented next cycle is the head of the
  // register image being written this cycle (Din on load, shifted otherwise).
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_w_n     = IDLE_BIT;
    w_busy_n  = 1'b0;
    w_done_n  = 1'b0;
    if (MSB_FIRST) begin
      w_shifted = {r_shift[WIDTH-2:0], 1'b0};
    end else begin
      w_shifted = {1'b0, r_shift[WIDTH-1:1]};
    end
    w_shift_n = r_shift;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_n = SHIFT;
          w_shift_n = Din;
          w_cnt_n   = CNT_LOAD;
          w_w_n     = head_of(Din);
          w_busy_n  = 1'b1;
        end
      end
      SHIFT: begin
        if (w_accept) begin
          // Gapless reload in the last-bit cycle.
          w_shift_n = Din;
          w_cnt_n   = CNT_LOAD;
          w_w_n     = head_of(Din);
          w_busy_n  = 1'b1;
        end else if (r_cnt != '0) begin
          w_shift_n = w_shifted;
          w_cnt_n   = r_cnt - CNT_ONE;
          w_w_n     = head_of(w_shifted);
          w_busy_n  = 1'b1;
          // Next cycle shows the last bit when the counter lands on zero.
          w_done_n  = (r_cnt == CNT_ONE);
        end else begin
          w_state_n = IDLE;
          w_shift_n = w_shifted;
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_w     <= IDLE_BIT;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_shift <= w_shift_n;
      r_cnt   <= w_cnt_n;
      r_w     <= w_w_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  assign Load_ready = w_ready;
  assign w          = r_w;
  assign Busy       = r_busy;
  assign Done       = r_done;

endmodule

// File: tb/tb_seq_bit_serializer.sv
module tb_seq_bit_serializer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Load_valid = 1'b0;
  logic [7:0] Din = 8'h00;
  logic       rdy_m, w_m, busy_m, done_m;
  logic       rdy_l, w_l, busy_l, done_l;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_m (
    .Clk(Clk), .Reset(Reset), .Din(Din), .Load_valid(Load_valid),
    .Load_ready(rdy_m), .w(w_m), .Busy(busy_m), .Done(done_m)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
    .Clk(Clk), .Reset(Reset), .Din(Din), .Load_valid(Load_valid),
    .Load_ready(rdy_l), .w(w_l), .Busy(busy_l), .Done(done_l)
  );

  initial forever #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the bits still to be shown on w, head = bit on w now.
  bit qm[$];
  bit ql[$];

  logic        obs_w, obs_busy, obs_done, obs_rdy;
  logic [15:0] cap_m, cap_l;
  int          dn_m, dn_l, bz_m;

  typedef struct {
    logic       rst;
    logic       lv;
    logic [7:0] din;
    logic       w;
    logic       busy;
    logic       done;
    logic       rdy;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic lv, input logic [7:0] din);
    bit acc;
    Reset      = rst;
    Load_valid = lv;
    Din        = din;
    @(negedge Clk);
    chk("w_msb",     w_m,    (qm.size() > 0) ? qm[0] : 1'b1);
    chk("busy_msb",  busy_m, qm.size() > 0);
    chk("done_msb",  done_m, qm.size() == 1);
    chk("ready_msb", rdy_m,  qm.size() <= 1);
    chk("w_lsb",     w_l,    (ql.size() > 0) ? ql[0] : 1'b1);
    chk("busy_lsb",  busy_l, ql.size() > 0);
    chk("done_lsb",  done_l, ql.size() == 1);
    chk("ready_lsb", rdy_l,  ql.size() <= 1);
    obs_w    = w_m;
    obs_busy = busy_m;
    obs_done = done_m;
    obs_rdy  = rdy_m;
    cap_m = {cap_m[14:0], w_m};
    cap_l = {cap_l[14:0], w_l};
    if (done_m) dn_m++;
    if (done_l) dn_l++;
    if (busy_m) bz_m++;
    @(posedge Clk);
    if (!rst) begin
      qm.delete();
      ql.delete();
    end else begin
      acc = lv && (qm.size() <= 1);
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (acc) begin
        for (int i = 0; i < 8; i++) begin
          qm.push_back(din[7-i]);
          ql.push_back(din[i]);
        end
      end
    end
    #1;
  endtask

  task automatic clr_obs();
    cap_m = '0;
    cap_l = '0;
    dn_m  = 0;
    dn_l  = 0;
    bz_m  = 0;
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] bits;
    int         hits;
    int         last_hit;
    a5 = 8'hA5;

    // Reset state, two clock edges with Reset low.
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'hFF);
    cycle(1'b1, 1'b0, 8'h00);

    // Test 1: A5 MSB-first, table-driven.
    tbl[0] = '{rst: 1'b1, lv: 1'b1, din: 8'hA5, w: 1'b1, busy: 1'b0, done: 1'b0, rdy: 1'b1};
    for (int i = 1; i <= 8; i++) begin
      tbl[i] = '{rst: 1'b1, lv: 1'b0, din: 8'h00, w: a5[8-i], busy: 1'b1,
                 done: (i == 8), rdy: (i == 8)};
    end
    tbl[9] = '{rst: 1'b1, lv: 1'b0, din: 8'h00, w: 1'b1, busy: 1'b0, done: 1'b0, rdy: 1'b1};
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].rst, tbl[i].lv, tbl[i].din);
      chk($sformatf("tbl%0d_w", i),     obs_w,    tbl[i].w);
      chk($sformatf("tbl%0d_busy", i),  obs_busy, tbl[i].busy);
      chk($sformatf("tbl%0d_done", i),  obs_done, tbl[i].done);
      chk($sformatf("tbl%0d_ready", i), obs_rdy,  tbl[i].rdy);
    end

    // Test 2: valid held high, F0 then 0F at the last bit -> 16 gapless bits.
    cycle(1'b1, 1'b1, 8'hF0);
    clr_obs();
    for (int i = 1; i <= 7; i++) cycle(1'b1, 1'b1, 8'hF0);
    cycle(1'b1, 1'b1, 8'h0F);
    for (int i = 9; i <= 16; i++) cycle(1'b1, 1'b0, 8'h00);
    chk("stream_f00f", cap_m, 16'hF00F);
    chk("stream_done_cnt", dn_m, 2);
    chk("stream_busy_cnt", bz_m, 16);
    cycle(1'b1, 1'b0, 8'h00);

    // Test 3: valid pulsed mid-word is ignored.
    cycle(1'b1, 1'b1, 8'hA5);
    clr_obs();
    for (int i = 1; i <= 8; i++) cycle(1'b1, (i == 3) || (i == 5), 8'h3C);
    chk("midword_bits", cap_m[7:0], 8'hA5);
    chk("midword_done_cnt", dn_m, 1);
    cycle(1'b1, 1'b0, 8'h00);
    chk("midword_idle_after", obs_w, 1'b1);

    // Test 4: reset after the 3rd bit of 55 aborts the word.
    cycle(1'b1, 1'b1, 8'h55);
    clr_obs();
    for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, 8'h00);
    chk("abort_first3", cap_m[2:0], 3'b010);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'hC3);
    chk("abort_w_idle", obs_w, 1'b1);
    chk("abort_busy", obs_busy, 1'b0);
    chk("abort_done_cnt", dn_m, 0);
    clr_obs();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 8'h00);
    chk("after_abort_word", cap_m[7:0], 8'hC3);
    chk("after_abort_done", dn_m, 1);

    // Test 5: LSB-first 01 -> 1 then seven 0s.
    cycle(1'b1, 1'b1, 8'h01);
    clr_obs();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 8'h00);
    chk("lsb_01_bits", cap_l[7:0], 8'b1000_0000);
    chk("lsb_01_done", dn_l, 1);

    // Test 6: 2A MSB-first; overlapping 101 ends at bits 5 and 7.
    cycle(1'b1, 1'b1, 8'h2A);
    clr_obs();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 8'h00);
    bits = cap_m[7:0];
    chk("det_2a_bits", bits, 8'b0010_1010);
    hits = 0;
    last_hit = 0;
    for (int i = 3; i <= 8; i++) begin
      if (bits[10-i] && !bits[9-i] && bits[8-i]) begin
        hits++;
        last_hit = i;
      end
    end
    chk("det_101_count", hits, 2);
    chk("det_101_last", last_hit, 7);

    // Randomised traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0), 8'($urandom));
    end
    cycle(1'b1, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
